// File: rtl/moore_det_pkg.sv
// Shared definitions for the time-shared "1010" Moore detector:
// state encoding, context width and the accept decode.
package moore_det_pkg;

  localparam int STATE_W = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam logic [2:0] S0 = 3'd0;  // nothing seen
  localparam logic [2:0] S1 = 3'd1;  // "1"
  localparam logic [2:0] S2 = 3'd2;  // "10"
  localparam logic [2:0] S3 = 3'd3;  // "101"
  localparam logic [2:0] S4 = 3'd4;  // "1010", Moore output high

  function automatic logic is_accept(input state_t s);
    return (s == S4);
  endfunction

endpackage

// File: rtl/moore_det_core.sv
// Combinational next-state logic of the overlapping "1010" Moore detector;
// shared by all channels through the context mux in the scheduler.
module moore_det_core
  import moore_det_pkg::*;
(
  input  state_t state,
  input  logic   data_bit,
  output state_t next_state,
  output logic   hit
);

  // next-state table; illegal encodings recover to S0
  always_comb begin
    next_state = S0;
    case (state)
      S0:      next_state = data_bit ? S1 : S0;
      S1:      next_state = data_bit ? S1 : S2;
      S2:      next_state = data_bit ? S3 : S0;
      S3:      next_state = data_bit ? S1 : S4;
      S4:      next_state = data_bit ? S3 : S0;
      default: next_state = S0;
    endcase
  end

  // S4 can only be entered from S3, so landing in S4 marks a new match
  always_comb begin
    hit = is_accept(next_state);
  end

endmodule

// File: rtl/moore_det_sched.sv
// Round-robin scheduler that time-shares one "1010" Moore detector among
// NCH serial channels, with a saved state context and match counter per channel.
module moore_det_sched
  import moore_det_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH-1:0]         req,
  input  logic [NCH-1:0]         bit_in,
  output logic [NCH-1:0]         gnt,
  output logic [NCH-1:0]         match,
  input  logic [$clog2(NCH)-1:0] cnt_sel,
  output logic [CW-1:0]          cnt_out
);

  localparam int SW = $clog2(NCH);
  localparam logic [SW-1:0] LAST_IDX = SW'(NCH - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  logic [SW-1:0] ptr_r;
  state_t        ctx_r [NCH];
  logic [CW-1:0] cnt_r [NCH];

  int            arb_idx_s;
  logic          found_s;
  logic          grant_v_s;
  logic [SW-1:0] gnt_idx_s;
  state_t        cur_state_s;
  logic          cur_bit_s;
  state_t        next_state_s;
  logic          hit_s;

  // search from ptr upward (wrapping) for the first pending requester
  always_comb begin
    found_s   = 1'b0;
    gnt_idx_s = {SW{1'b0}};
    arb_idx_s = 0;
    for (int o = 0; o < NCH; o++) begin
      arb_idx_s = int'(ptr_r) + o;
      if (arb_idx_s >= NCH) begin
        arb_idx_s = arb_idx_s - NCH;
      end else begin
        arb_idx_s = arb_idx_s;
      end
      if (!found_s && req[arb_idx_s]) begin
        found_s   = 1'b1;
        gnt_idx_s = SW'(arb_idx_s);
      end else begin
        found_s   = found_s;
      end
    end
  end

  // nothing is consumed during a reset cycle
  always_comb begin
    grant_v_s = found_s & ~rst;
  end

  // one-hot grant to the selected channel
  always_comb begin
    gnt = {NCH{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      gnt[i] = grant_v_s && (gnt_idx_s == SW'(i));
    end
  end

  // AND-OR mux of the granted channel's context and data bit into the core
  always_comb begin
    cur_state_s = S0;
    cur_bit_s   = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      cur_state_s = cur_state_s | (ctx_r[i] & {STATE_W{gnt_idx_s == SW'(i)}});
      cur_bit_s   = cur_bit_s | (bit_in[i] & (gnt_idx_s == SW'(i)));
    end
  end

  moore_det_core u_core (
    .state      (cur_state_s),
    .data_bit   (cur_bit_s),
    .next_state (next_state_s),
    .hit        (hit_s)
  );

  // round-robin pointer moves just past the channel that was served
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= {SW{1'b0}};
    end else if (grant_v_s) begin
      ptr_r <= (gnt_idx_s == LAST_IDX) ? {SW{1'b0}} : gnt_idx_s + SW'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // only the granted channel's context advances; the rest hold
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (rst) begin
        ctx_r[i] <= S0;
      end else if (grant_v_s && (gnt_idx_s == SW'(i))) begin
        ctx_r[i] <= next_state_s;
      end else begin
        ctx_r[i] <= ctx_r[i];
      end
    end
  end

  // saturating per-channel count of entries into S4
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (rst) begin
        cnt_r[i] <= {CW{1'b0}};
      end else if (grant_v_s && (gnt_idx_s == SW'(i)) && hit_s && (cnt_r[i] != CNT_MAX)) begin
        cnt_r[i] <= cnt_r[i] + CW'(1);
      end else begin
        cnt_r[i] <= cnt_r[i];
      end
    end
  end

  // Moore outputs decode only the stored contexts
  always_comb begin
    match = {NCH{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      match[i] = is_accept(ctx_r[i]);
    end
  end

  // counter read port; selects at or above NCH match nothing and read 0
  always_comb begin
    cnt_out = {CW{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      cnt_out = cnt_out | (cnt_r[i] & {CW{cnt_sel == SW'(i)}});
    end
  end

endmodule

// File: tb/tb_moore_det_sched.sv
// Self-checking bench for moore_det_sched: directed scenarios plus random
// traffic compared against a bit-history reference model.
module tb_moore_det_sched;

  localparam int N = 4;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] req, bit_in, gnt, match;
  logic [1:0] cnt_sel;
  logic [7:0] cnt_out;

  logic       rst_b;
  logic [2:0] req_b, bit_b, gnt_b, match_b;
  logic [1:0] sel_b;
  logic [1:0] cnt_b;

  int errors = 0;
  int checks = 0;

  // reference model: last four consumed bits per channel, match counts, pointer
  logic [3:0] hist [N];
  int         nb   [N];
  int         mcnt [N];
  int         mptr;

  moore_det_sched #(.NCH(4), .CW(8)) dut (
    .clk(clk), .rst(rst), .req(req), .bit_in(bit_in), .gnt(gnt),
    .match(match), .cnt_sel(cnt_sel), .cnt_out(cnt_out)
  );

  moore_det_sched #(.NCH(3), .CW(2)) dut_b (
    .clk(clk), .rst(rst_b), .req(req_b), .bit_in(bit_b), .gnt(gnt_b),
    .match(match_b), .cnt_sel(sel_b), .cnt_out(cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r);
    for (int o = 0; o < N; o++) begin
      if (r[(mptr + o) % N]) return (mptr + o) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      hist[i] = 4'b0000;
      nb[i]   = 0;
      mcnt[i] = 0;
    end
    mptr = 0;
  endtask

  // one clock cycle: drive, check grant, clock, update model, check outputs
  task automatic step(input logic r_rst, input logic [3:0] r, input logic [3:0] b);
    int k;
    rst = r_rst; req = r; bit_in = b;
    #1;
    k = r_rst ? -1 : pick(r);
    chk("gnt", {28'd0, gnt}, (k < 0) ? 32'd0 : (32'd1 << k));
    @(posedge clk);
    #1;
    if (r_rst) begin
      model_reset();
    end else if (k >= 0) begin
      hist[k] = {hist[k][2:0], b[k]};
      nb[k]++;
      if (hist[k] == 4'b1010 && mcnt[k] < 255) mcnt[k]++;
      mptr = (k + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      chk($sformatf("match%0d", i), {31'd0, match[i]}, {31'd0, hist[i] == 4'b1010});
    end
    for (int i = 0; i < N; i++) begin
      cnt_sel = 2'(i);
      #1;
      chk($sformatf("cnt%0d", i), {24'd0, cnt_out}, 32'(mcnt[i]));
    end
  endtask

  initial begin
    logic [5:0] s0;
    logic [3:0] b;
    logic [3:0] pend;
    logic [3:0] pbit;
    logic       rr;
    int         k;
    logic [3:0] hb;
    int         cb;

    rst = 1'b1; rst_b = 1'b1;
    req = 4'b0000; bit_in = 4'b0000; cnt_sel = 2'd0;
    req_b = 3'b000; bit_b = 3'b000; sel_b = 2'd0;
    model_reset();
    @(posedge clk);
    #1;

    // reset cycle with all requests high: no grant, all state cleared
    step(1'b1, 4'b1111, 4'b1111);

    // channel 0 alone: 1,0,1,0,1,0 -> matches after bits 4 and 6
    s0 = 6'b101010;
    for (int j = 0; j < 6; j++) step(1'b0, 4'b0001, {3'b000, s0[5 - j]});
    // idle: match holds, pointer holds
    repeat (3) step(1'b0, 4'b0000, 4'b0000);

    // all channels requesting, each fed its own 1010 stream
    step(1'b1, 4'b0000, 4'b0000);
    for (int c = 0; c < 16; c++) begin
      for (int i = 0; i < N; i++) b[i] = (nb[i] % 2 == 0);
      step(1'b0, 4'b1111, b);
    end

    // pointer at 1, then req 0101 -> 0100, 0001, 0100
    step(1'b1, 4'b0000, 4'b0000);
    step(1'b0, 4'b0001, 4'b0001);
    step(1'b0, 4'b0101, 4'b0100);
    step(1'b0, 4'b0101, 4'b0000);
    step(1'b0, 4'b0101, 4'b0000);

    // channel 2 reaches "101", reset, then a 0 must not complete the pattern
    step(1'b1, 4'b0000, 4'b0000);
    step(1'b0, 4'b0100, 4'b0100);
    step(1'b0, 4'b0100, 4'b0000);
    step(1'b0, 4'b0100, 4'b0100);
    step(1'b1, 4'b0100, 4'b0000);
    step(1'b0, 4'b0100, 4'b0000);

    // random traffic; requesters hold req and bit until granted
    pend = 4'b0000; pbit = 4'b0000;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          pbit[i] = 1'($urandom_range(0, 1));
        end
      end
      rr = ($urandom_range(0, 39) == 0);
      k  = rr ? -1 : pick(pend);
      step(rr, pend, pbit);
      if (k >= 0) pend[k] = 1'b0;
    end
    step(1'b0, 4'b0000, 4'b0000);

    // second instance, CW=2: channel 1 fed 1010 five times saturates at 3
    rst_b = 1'b0; req_b = 3'b010; sel_b = 2'd1;
    hb = 4'b0000; cb = 0;
    for (int j = 0; j < 20; j++) begin
      bit_b = {1'b0, (j % 2 == 0), 1'b0};
      #1;
      chk("gnt_b", {29'd0, gnt_b}, 32'd2);
      @(posedge clk);
      #1;
      hb = {hb[2:0], (j % 2 == 0)};
      if (hb == 4'b1010 && cb < 3) cb++;
      chk("match_b", {31'd0, match_b[1]}, {31'd0, hb == 4'b1010});
      chk("cnt_b", {30'd0, cnt_b}, 32'(cb));
    end
    req_b = 3'b000;
    sel_b = 2'd3;
    #1;
    chk("cnt_b_oob", {30'd0, cnt_b}, 32'd0);
    sel_b = 2'd1;
    #1;
    chk("cnt_b_sat", {30'd0, cnt_b}, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
